regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the pipelined MIPS datapath, with write-through bypass and a per-register busy scoreboard. It replaces the falling-edge-write scheme: writes commit on the rising edge, and same-cycle read-after-write is resolved by an internal bypass. The scoreboard tracks registers with an in-flight producer so that hazard logic in the decode stage can stall without comparing pipeline destination fields itself. It sits in the decode stage; the write port is driven from writeback.

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: one write port from writeback, NRD read ports,
// and the scoreboard reservation port.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) ();

  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rd_busy;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic [AW:0]          nbusy;

  modport master (
    output we, wa, wd, ra, rsv_en, rsv_addr,
    input  rd, rd_busy, nbusy
  );

  modport slave (
    input  we, wa, wd, ra, rsv_en, rsv_addr,
    output rd, rd_busy, nbusy
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a per-register busy
// scoreboard so decode can stall on in-flight producers directly.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int NREG = 1 << AW;

  logic [WIDTH-1:0] mem [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [AW:0]      nbusy_q;
  logic [AW:0]      nbusy_nxt;
  logic             wr_ok;

  assign wr_ok = bus.we && !(ZERO_REG && (bus.wa == '0));

  // The reservation is applied after the clear so a same-cycle reserve of the
  // register being written leaves it busy: it names a newer producer.
  always_comb begin
    // NOTE: default assignment first so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (bus.we)     busy_nxt[bus.wa]       = 1'b0;
    if (bus.rsv_en) busy_nxt[bus.rsv_addr] = 1'b1;
    if (ZERO_REG)   busy_nxt[0]            = 1'b0;
  end

  // Count the next state so nbusy lines up with the busy bits at the same edge.
  always_comb begin
    nbusy_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      nbusy_nxt = nbusy_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  // NOTE: the storage array is built from flops and is cleared by reset, because
  // software expects every register to read 0 after reset, not RAM contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
      busy    <= '0;
      nbusy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (wr_ok) mem[bus.wa] <= bus.wd;
      busy    <= busy_nxt;
      nbusy_q <= nbusy_nxt;
    end
  end

  assign bus.nbusy = nbusy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic          zero;

    assign addr = bus.ra[i*AW +: AW];
    assign hit  = bus.we && (bus.wa == addr);
    assign zero = ZERO_REG && (addr == '0);

    assign bus.rd[i*WIDTH +: WIDTH] = zero ? '0 : (hit ? bus.wd : mem[addr]);
    // The value being written is already forwarded, so the port is not stalled.
    assign bus.rd_busy[i] = busy[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, zero register, scoreboard and
// asynchronous mid-run reset, with hand-computed expectations.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NRD(2)) bus ();

  regfile_mp #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rd0, rd1;
  assign rd0 = bus.rd[31:0];
  assign rd1 = bus.rd[63:32];

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_ra(5'd0, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      set_ra(5'(r), 5'(31 - r));
      #1;
      checks++;
      if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd r=%0d got %h/%h exp 0/0", r, rd0, rd1);
      end
      checks++;
      if (bus.rd_busy !== 2'b00 || bus.nbusy !== 6'd0) begin
        errors++;
        $display("FAIL reset_busy r=%0d got busy=%b nbusy=%0d exp 00/0", r, bus.rd_busy, bus.nbusy);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1234_5678;
    set_ra(5'd5, 5'd4);
    #1;
    checks++;
    if (rd0 !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_rd got %h exp 12345678", rd0);
    end
    checks++;
    if (rd1 !== 32'h0) begin
      errors++; $display("FAIL bypass_other_port got %h exp 0", rd1);
    end
    @(negedge clk);
    idle();
    set_ra(5'd5, 5'd5);
    #1;
    checks++;
    if (rd0 !== 32'h1234_5678 || rd1 !== 32'h1234_5678) begin
      errors++; $display("FAIL stored_rd got %h/%h exp 12345678/12345678", rd0, rd1);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFF_FFFF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    set_ra(5'd0, 5'd5);
    #1;
    checks++;
    if (rd0 !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_same_cycle got rd=%h busy=%b exp 0/0", rd0, bus.rd_busy[0]);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rd0 !== 32'h0 || bus.rd_busy[0] !== 1'b0 || bus.nbusy !== 6'd0) begin
      errors++;
      $display("FAIL zero_after got rd=%h busy=%b nbusy=%0d exp 0/0/0", rd0, bus.rd_busy[0], bus.nbusy);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    @(negedge clk);
    #1;
    checks++;
    if (bus.nbusy !== 6'd1) begin
      errors++; $display("FAIL nbusy_rsv3 got %0d exp 1", bus.nbusy);
    end
    bus.rsv_addr = 5'd7;
    @(negedge clk);
    idle();
    set_ra(5'd3, 5'd7);
    #1;
    checks++;
    if (bus.nbusy !== 6'd2 || bus.rd_busy !== 2'b11) begin
      errors++; $display("FAIL nbusy_rsv7 got nbusy=%0d busy=%b exp 2/11", bus.nbusy, bus.rd_busy);
    end
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hAAAA_0003;
    #1;
    checks++;
    if (bus.rd_busy !== 2'b10 || rd0 !== 32'hAAAA_0003) begin
      errors++; $display("FAIL write_r3_cycle got busy=%b rd=%h exp 10/aaaa0003", bus.rd_busy, rd0);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.nbusy !== 6'd1 || bus.rd_busy !== 2'b10 || rd0 !== 32'hAAAA_0003) begin
      errors++;
      $display("FAIL write_r3_after got nbusy=%0d busy=%b rd=%h exp 1/10/aaaa0003", bus.nbusy, bus.rd_busy, rd0);
    end
  endtask

  task automatic test_rsv_write_same();
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h0000_9999;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    set_ra(5'd9, 5'd7);
    #1;
    checks++;
    if (rd0 !== 32'h0000_9999 || bus.rd_busy !== 2'b10) begin
      errors++; $display("FAIL rsvwr9_cycle got rd=%h busy=%b exp 00009999/10", rd0, bus.rd_busy);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rd0 !== 32'h0000_9999 || bus.rd_busy !== 2'b11 || bus.nbusy !== 6'd2) begin
      errors++;
      $display("FAIL rsvwr9_after got rd=%h busy=%b nbusy=%0d exp 00009999/11/2", rd0, bus.rd_busy, bus.nbusy);
    end
    // Re-reserve an already-busy register and write a non-busy one together.
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 32'hC0DE_000C;
    @(negedge clk);
    idle();
    set_ra(5'd12, 5'd7);
    #1;
    checks++;
    if (bus.nbusy !== 6'd2 || bus.rd_busy !== 2'b10 || rd0 !== 32'hC0DE_000C) begin
      errors++;
      $display("FAIL rebusy_nonbusy_wr got nbusy=%0d busy=%b rd=%h exp 2/10/c0de000c", bus.nbusy, bus.rd_busy, rd0);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 20; k < 24; k++) begin
      @(negedge clk);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'(k);
    end
    @(negedge clk);
    idle();
    bus.we = 1'b1; bus.wa = 5'd20; bus.wd = 32'h2020_2020;
    @(negedge clk);
    bus.wa = 5'd21; bus.wd = 32'h2121_2121;
    @(negedge clk);
    idle();
    set_ra(5'd5, 5'd22);
    #1;
    checks++;
    if (bus.nbusy !== 6'd4 || bus.rd_busy !== 2'b10 || rd0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL pre_reset got nbusy=%0d busy=%b rd=%h exp 4/10/12345678", bus.nbusy, bus.rd_busy, rd0);
    end
    #1;
    bus.we = 1'b1; bus.wa = 5'd6; bus.wd = 32'h6666_6666;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.nbusy !== 6'd0 || bus.rd_busy !== 2'b00 || rd0 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got nbusy=%0d busy=%b rd=%h exp 0/00/0", bus.nbusy, bus.rd_busy, rd0);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    set_ra(5'd20, 5'd6);
    #1;
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0 || bus.nbusy !== 6'd0) begin
      errors++;
      $display("FAIL post_reset got rd=%h/%h nbusy=%0d exp 0/0/0", rd0, rd1, bus.nbusy);
    end
    @(negedge clk);
    set_ra(5'd21, 5'd9);
    #1;
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0 || bus.rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset2 got rd=%h/%h busy=%b exp 0/0/00", rd0, rd1, bus.rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_rsv_write_same();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
